// File: rtl/cv32e40px_hwloop_pkg.sv
// Shared types and constants for the hardware-loop controller.
// Optional jump counter is enabled with CV32E40PX_HWLP_PERF_EN.
package cv32e40px_hwloop_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hwlp_ctrl_state_e;

  localparam int unsigned HWLP_INSTR_BYTES = 4;
  localparam int unsigned HWLP_CNT_WE_BIT  = 2;

  // End addresses are exclusive, so the last body instruction sits one word below.
  function automatic logic [31:0] hwlp_last_pc(input logic [31:0] end_addr);
    return end_addr - 32'(HWLP_INSTR_BYTES);
  endfunction

endpackage

// File: rtl/cv32e40px_hwloop_match.sv
// Per-loop end-address compare with lowest-index (innermost) priority.
// Produces the raw decision; holding and cancelling live in the top.
module cv32e40px_hwloop_match
  import cv32e40px_hwloop_pkg::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                        en_i,
  input  logic [31:0]                 current_pc_i,
  input  logic [N_REGS-1:0][31:0]     hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]     hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]     hwlp_counter_i,
  output logic                        match_o,
  output logic [N_REG_BITS-1:0]       idx_o,
  output logic                        jump_o,
  output logic [31:0]                 targ_o
);

  logic [N_REGS-1:0] hit;

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_REGS; k++) begin
      hit[k] = en_i && (hwlp_counter_i[k] != 32'd0) &&
               (current_pc_i == hwlp_last_pc(hwlp_end_addr_i[k]));
    end
  end

  always_comb begin
    match_o = 1'b0;
    idx_o   = '0;
    // Walk downwards so the lowest matching index is the one left standing.
    for (int k = N_REGS - 1; k >= 0; k--) begin
      if (hit[k]) begin
        match_o = 1'b1;
        idx_o   = N_REG_BITS'(k);
      end
    end
    jump_o = match_o && (hwlp_counter_i[idx_o] > 32'd1);
    targ_o = match_o ? hwlp_start_addr_i[idx_o] : 32'd0;
  end

endmodule

// File: rtl/cv32e40px_hwloop_ctrl.sv
// Hardware-loop consumer: jump-back decision and decrement strobes, held across ID stalls.
// Define CV32E40PX_HWLP_PERF_EN to add a saturating taken-jump counter on hwlp_jump_cnt_o.
module cv32e40px_hwloop_ctrl
  import cv32e40px_hwloop_pkg::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 current_pc_i,
  input  logic                        pc_valid_i,
  input  logic                        valid_i,
  input  logic                        flush_i,
  input  logic [N_REGS-1:0][31:0]     hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]     hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]     hwlp_counter_i,
  input  logic [2:0]                  hwlp_we_i,
  input  logic [N_REG_BITS-1:0]       hwlp_regid_i,
  output logic                        hwlp_jump_o,
  output logic [31:0]                 hwlp_targ_addr_o,
  output logic [N_REGS-1:0]           hwlp_dec_cnt_o,
  output logic [31:0]                 hwlp_jump_cnt_o
);

  hwlp_ctrl_state_e        state_q, state_d;
  logic [N_REG_BITS-1:0]   idx_q, idx_d;
  logic                    jump_q, jump_d;
  logic [31:0]             targ_q, targ_d;

  logic                    m_match;
  logic [N_REG_BITS-1:0]   m_idx;
  logic                    m_jump;
  logic [31:0]             m_targ;
  logic                    cnt_rewrite;

  cv32e40px_hwloop_match #(
    .N_REGS     (N_REGS),
    .N_REG_BITS (N_REG_BITS)
  ) u_match (
    .en_i              (pc_valid_i && !flush_i),
    .current_pc_i      (current_pc_i),
    .hwlp_start_addr_i (hwlp_start_addr_i),
    .hwlp_end_addr_i   (hwlp_end_addr_i),
    .hwlp_counter_i    (hwlp_counter_i),
    .match_o           (m_match),
    .idx_o             (m_idx),
    .jump_o            (m_jump),
    .targ_o            (m_targ)
  );

  // A counter write wins in the register file, so a held decision on that loop is stale.
  assign cnt_rewrite = hwlp_we_i[HWLP_CNT_WE_BIT] && (hwlp_regid_i == idx_q);

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    jump_d           = jump_q;
    targ_d           = targ_q;
    hwlp_jump_o      = 1'b0;
    hwlp_targ_addr_o = 32'd0;
    hwlp_dec_cnt_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (m_match) begin
          hwlp_jump_o           = m_jump;
          hwlp_targ_addr_o      = m_targ;
          hwlp_dec_cnt_o[m_idx] = 1'b1;
          if (!valid_i) begin
            state_d = HOLD;
            idx_d   = m_idx;
            jump_d  = m_jump;
            targ_d  = m_targ;
          end
        end
      end
      HOLD: begin
        if (flush_i || cnt_rewrite) begin
          state_d = IDLE;
        end else begin
          hwlp_jump_o           = jump_q;
          hwlp_targ_addr_o      = targ_q;
          hwlp_dec_cnt_o[idx_q] = 1'b1;
          if (valid_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      jump_q  <= 1'b0;
      targ_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      jump_q  <= jump_d;
      targ_q  <= targ_d;
    end
  end

`ifdef CV32E40PX_HWLP_PERF_EN
  logic [31:0] jump_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_cnt_q <= 32'd0;
    end else if (hwlp_jump_o && valid_i && !flush_i && (jump_cnt_q != 32'hFFFF_FFFF)) begin
      jump_cnt_q <= jump_cnt_q + 32'd1;
    end
  end

  assign hwlp_jump_cnt_o = jump_cnt_q;
`else
  assign hwlp_jump_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cv32e40px_hwloop_ctrl.sv
// Scoreboard bench for the hardware-loop controller: expected decisions are queued per cycle.
module tb_cv32e40px_hwloop_ctrl;

  typedef struct packed {
    logic        jump;
    logic [31:0] targ;
    logic [1:0]  dec;
  } exp_t;

  typedef struct packed {
    logic        pcv;
    logic        vld;
    logic        fl;
    logic [2:0]  we;
    logic        rid;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [31:0] pc;
    exp_t        e;
  } step_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       current_pc = '0;
  logic              pc_valid = 1'b0;
  logic              valid = 1'b0;
  logic              flush = 1'b0;
  logic [1:0][31:0]  start_addr = '0;
  logic [1:0][31:0]  end_addr = '0;
  logic [1:0][31:0]  counter = '0;
  logic [2:0]        we = '0;
  logic              regid = 1'b0;
  logic              hwlp_jump;
  logic [31:0]       hwlp_targ;
  logic [1:0]        hwlp_dec;
  logic [31:0]       hwlp_jump_cnt;

  exp_t        scb[$];
  exp_t        obs, want;
  logic [31:0] perf_model = '0;
  logic [31:0] perf_want;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  cv32e40px_hwloop_ctrl #(.N_REGS(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .current_pc_i      (current_pc),
    .pc_valid_i        (pc_valid),
    .valid_i           (valid),
    .flush_i           (flush),
    .hwlp_start_addr_i (start_addr),
    .hwlp_end_addr_i   (end_addr),
    .hwlp_counter_i    (counter),
    .hwlp_we_i         (we),
    .hwlp_regid_i      (regid),
    .hwlp_jump_o       (hwlp_jump),
    .hwlp_targ_addr_o  (hwlp_targ),
    .hwlp_dec_cnt_o    (hwlp_dec),
    .hwlp_jump_cnt_o   (hwlp_jump_cnt)
  );

  function automatic step_t mk(logic pcv, logic vld, logic fl, logic [2:0] w, logic rid,
                               logic [31:0] c0, logic [31:0] c1, logic [31:0] pc,
                               logic j, logic [31:0] t, logic [1:0] d);
    step_t s;
    s.pcv = pcv; s.vld = vld; s.fl = fl; s.we = w; s.rid = rid;
    s.c0 = c0; s.c1 = c1; s.pc = pc;
    s.e.jump = j; s.e.targ = t; s.e.dec = d;
    return s;
  endfunction

  // Drive one cycle just after the rising edge, queue its expectation, sample at the falling edge.
  task automatic apply(input step_t s);
    @(posedge clk); #1;
    pc_valid   = s.pcv;
    valid      = s.vld;
    flush      = s.fl;
    we         = s.we;
    regid      = s.rid;
    counter[0] = s.c0;
    counter[1] = s.c1;
    current_pc = s.pc;
    scb.push_back(s.e);
    @(negedge clk);
    obs = {hwlp_jump, hwlp_targ, hwlp_dec};
    if (s.e.jump && s.vld && !s.fl && perf_model != 32'hFFFF_FFFF) perf_model++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({hwlp_jump, hwlp_targ, hwlp_dec} !== 35'd0) begin
      n_mis++;
      $display("FAIL reset_outputs got jump=%0b targ=%h dec=%b want all zero", hwlp_jump, hwlp_targ, hwlp_dec);
    end
    n_cmp++;
    if (hwlp_jump_cnt !== 32'd0) begin
      n_mis++;
      $display("FAIL reset_jump_cnt got %h want 0", hwlp_jump_cnt);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_single();
    step_t t[$];
    start_addr[0] = 32'h100; end_addr[0] = 32'h110;
    start_addr[1] = 32'h200; end_addr[1] = 32'h300;
    t.push_back(mk(1,1,0,3'b000,0, 3,0,32'h10C, 1,32'h100,2'b01));
    t.push_back(mk(1,1,0,3'b000,0, 1,0,32'h10C, 0,32'h100,2'b01));
    t.push_back(mk(1,1,0,3'b000,0, 3,0,32'h110, 0,32'h0,2'b00));
    t.push_back(mk(0,1,0,3'b000,0, 3,0,32'h10C, 0,32'h0,2'b00));
    t.push_back(mk(1,1,0,3'b000,0, 0,0,32'h10C, 0,32'h0,2'b00));
    foreach (t[i]) begin
      apply(t[i]);
      want = scb.pop_front();
      n_cmp++;
      if (obs !== want) begin
        n_mis++;
        $display("FAIL single[%0d] got %b/%h/%b want %b/%h/%b", i, obs.jump, obs.targ, obs.dec, want.jump, want.targ, want.dec);
      end
    end
  endtask

  task automatic test_stall();
    step_t t[$];
    t.push_back(mk(1,0,0,3'b000,0, 3,0,32'h10C, 1,32'h100,2'b01));
    t.push_back(mk(1,0,0,3'b000,0, 1,0,32'h10C, 1,32'h100,2'b01));
    t.push_back(mk(0,0,0,3'b000,0, 0,0,32'h0,   1,32'h100,2'b01));
    t.push_back(mk(1,1,0,3'b000,0, 3,0,32'h10C, 1,32'h100,2'b01));
    t.push_back(mk(0,1,0,3'b000,0, 3,0,32'h10C, 0,32'h0,2'b00));
    foreach (t[i]) begin
      apply(t[i]);
      want = scb.pop_front();
      n_cmp++;
      if (obs !== want) begin
        n_mis++;
        $display("FAIL stall[%0d] got %b/%h/%b want %b/%h/%b", i, obs.jump, obs.targ, obs.dec, want.jump, want.targ, want.dec);
      end
    end
  endtask

  task automatic test_nested();
    step_t t[$];
    start_addr[1] = 32'h200; end_addr[1] = 32'h110;
    t.push_back(mk(1,1,0,3'b000,0, 2,5,32'h10C, 1,32'h100,2'b01));
    t.push_back(mk(1,1,0,3'b000,0, 0,5,32'h10C, 1,32'h200,2'b10));
    t.push_back(mk(1,1,0,3'b000,0, 0,1,32'h10C, 0,32'h200,2'b10));
    t.push_back(mk(1,1,1,3'b000,0, 2,5,32'h10C, 0,32'h0,2'b00));
    foreach (t[i]) begin
      apply(t[i]);
      want = scb.pop_front();
      n_cmp++;
      if (obs !== want) begin
        n_mis++;
        $display("FAIL nested[%0d] got %b/%h/%b want %b/%h/%b", i, obs.jump, obs.targ, obs.dec, want.jump, want.targ, want.dec);
      end
    end
  endtask

  task automatic test_flush_hold();
    step_t t[$];
    t.push_back(mk(1,0,0,3'b000,0, 2,5,32'h10C, 1,32'h100,2'b01));
    t.push_back(mk(1,1,1,3'b000,0, 2,5,32'h10C, 0,32'h0,2'b00));
    t.push_back(mk(1,1,0,3'b000,0, 1,5,32'h10C, 0,32'h100,2'b01));
    foreach (t[i]) begin
      apply(t[i]);
      want = scb.pop_front();
      n_cmp++;
      if (obs !== want) begin
        n_mis++;
        $display("FAIL flush_hold[%0d] got %b/%h/%b want %b/%h/%b", i, obs.jump, obs.targ, obs.dec, want.jump, want.targ, want.dec);
      end
    end
  endtask

  task automatic test_rewrite();
    step_t t[$];
    step_t u[$];
    t.push_back(mk(1,0,0,3'b000,0, 0,5,32'h10C, 1,32'h200,2'b10));
    t.push_back(mk(1,0,0,3'b100,1, 0,5,32'h10C, 0,32'h0,2'b00));
    t.push_back(mk(0,0,0,3'b000,0, 0,5,32'h10C, 0,32'h0,2'b00));
    t.push_back(mk(1,0,0,3'b000,0, 0,5,32'h10C, 1,32'h200,2'b10));
    t.push_back(mk(1,0,0,3'b100,0, 0,5,32'h10C, 1,32'h200,2'b10));
    foreach (t[i]) begin
      apply(t[i]);
      want = scb.pop_front();
      n_cmp++;
      if (obs !== want) begin
        n_mis++;
        $display("FAIL rewrite[%0d] got %b/%h/%b want %b/%h/%b", i, obs.jump, obs.targ, obs.dec, want.jump, want.targ, want.dec);
      end
    end
    // Start/end writes to the held loop leave the latched target alone.
    start_addr[1] = 32'h300;
    u.push_back(mk(1,0,0,3'b011,1, 0,5,32'h10C, 1,32'h200,2'b10));
    u.push_back(mk(1,1,0,3'b000,0, 0,5,32'h10C, 1,32'h200,2'b10));
    u.push_back(mk(0,1,0,3'b000,0, 0,5,32'h10C, 0,32'h0,2'b00));
    u.push_back(mk(1,1,0,3'b000,0, 0,5,32'h10C, 1,32'h300,2'b10));
    foreach (u[i]) begin
      apply(u[i]);
      want = scb.pop_front();
      n_cmp++;
      if (obs !== want) begin
        n_mis++;
        $display("FAIL rewrite_keep[%0d] got %b/%h/%b want %b/%h/%b", i, obs.jump, obs.targ, obs.dec, want.jump, want.targ, want.dec);
      end
    end
  endtask

  task automatic test_wrap();
    step_t t[$];
    start_addr[0] = 32'h40; end_addr[0] = 32'h0;
    start_addr[1] = 32'h200; end_addr[1] = 32'h300;
    t.push_back(mk(1,1,0,3'b000,0, 2,0,32'hFFFF_FFFC, 1,32'h40,2'b01));
    t.push_back(mk(1,1,0,3'b000,0, 2,0,32'hFFFF_FFF8, 0,32'h0,2'b00));
    foreach (t[i]) begin
      apply(t[i]);
      want = scb.pop_front();
      n_cmp++;
      if (obs !== want) begin
        n_mis++;
        $display("FAIL wrap[%0d] got %b/%h/%b want %b/%h/%b", i, obs.jump, obs.targ, obs.dec, want.jump, want.targ, want.dec);
      end
    end
  endtask

  task automatic test_reset_hold();
    apply(mk(1,0,0,3'b000,0, 2,0,32'hFFFF_FFFC, 1,32'h40,2'b01));
    want = scb.pop_front();
    n_cmp++;
    if (obs !== want) begin
      n_mis++;
      $display("FAIL reset_hold_enter got %b/%h/%b want %b/%h/%b", obs.jump, obs.targ, obs.dec, want.jump, want.targ, want.dec);
    end
    #1 pc_valid = 1'b0;
    rst_n = 1'b0;
    perf_model = '0;
    #1;
    n_cmp++;
    if ({hwlp_jump, hwlp_targ, hwlp_dec} !== 35'd0) begin
      n_mis++;
      $display("FAIL reset_hold_clear got jump=%0b targ=%h dec=%b want all zero", hwlp_jump, hwlp_targ, hwlp_dec);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    apply(mk(0,0,0,3'b000,0, 2,0,32'hFFFF_FFFC, 0,32'h0,2'b00));
    want = scb.pop_front();
    n_cmp++;
    if (obs !== want) begin
      n_mis++;
      $display("FAIL reset_hold_idle got %b/%h/%b want %b/%h/%b", obs.jump, obs.targ, obs.dec, want.jump, want.targ, want.dec);
    end
  endtask

  task automatic test_perf();
    step_t t[$];
    start_addr[0] = 32'h100; end_addr[0] = 32'h110;
    for (int i = 0; i < 5; i++) t.push_back(mk(1,1,0,3'b000,0, 3,0,32'h10C, 1,32'h100,2'b01));
    t.push_back(mk(1,1,1,3'b000,0, 3,0,32'h10C, 0,32'h0,2'b00));
    t.push_back(mk(0,0,0,3'b000,0, 3,0,32'h10C, 0,32'h0,2'b00));
    foreach (t[i]) begin
      apply(t[i]);
      want = scb.pop_front();
      n_cmp++;
      if (obs !== want) begin
        n_mis++;
        $display("FAIL perf_seq[%0d] got %b/%h/%b want %b/%h/%b", i, obs.jump, obs.targ, obs.dec, want.jump, want.targ, want.dec);
      end
    end
`ifdef CV32E40PX_HWLP_PERF_EN
    perf_want = perf_model;
`else
    perf_want = 32'd0;
`endif
    n_cmp++;
    if (hwlp_jump_cnt !== perf_want) begin
      n_mis++;
      $display("FAIL perf_count got %0d want %0d", hwlp_jump_cnt, perf_want);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_nested();
    test_flush_hold();
    test_rewrite();
    test_wrap();
    test_reset_hold();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
